decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined, parametrised decode stage for the 16-bit core. It sits between the IF/ID and ID/EX boundaries and decodes one 16-bit instruction per cycle into register addresses, a sign-extended immediate and control signals, all held in an ID/EX output register. Beyond a plain combinational decode it adds a valid/ready handshake, load-use stall insertion, branch flush, a sticky halt latch and illegal-opcode detection.

## Interface
- PC_W, 16, width of the PC and PC+2 buses
- DATA_W, 16, width of the sign-extended immediate
- LOADUSE_STALL, 1, 1 = detect load-use hazards and insert a bubble; 0 = never stall on hazards

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  decode accepts the instruction this cycle (combinational)
- in_inst  in  16  instruction word
- in_pc, in_pc_plus2  in  PC_W  PC and PC+2 of the instruction
- flush  in  1  EX resolved a taken branch or jump; kill the instruction in decode
- ex_ready  in  1  EX can take the ID/EX contents this cycle
- rf_rs_addr, rf_rt_addr  out  3  register-file read addresses (combinational from in_inst)
- out_valid  out  1  ID/EX holds a valid instruction
- out_pc, out_pc_plus2  out  PC_W  registered PC values
- out_rd, out_rs, out_rt  out  3  registered register numbers
- out_imm  out  DATA_W  sign-extended immediate
- out_alu_ctrl  out  3  ALU operation
- out_use_imm, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_jump  out  1  control bits
- halted  out  1  sticky; a HALT has been accepted
- illegal  out  1  sticky; an undefined opcode has been accepted

## Operation
- The opcode is inst[15:12]. The Rd field is inst[11:9] when inst[14]=1, else inst[5:3]. Rs = inst[8:6]. Rt = inst[11:9].
- 0000 NOP: no control bits set.
- 0001 HALT: sets halted on acceptance. After that, in_ready stays 0 until reset. The HALT itself propagates as a NOP.
- 0010 BRANCH: out_branch=1. Compares Rs and Rt. imm = sext(inst[5:0]).
- 0011 JUMP: out_jump=1. imm = sext(inst[11:0]).
- 0100 ADDI: wr_en=1, use_imm=1, alu_ctrl=000, imm = sext(inst[5:0]).
- 0101 LD: wr_en=1, mem_rd=1, use_imm=1, alu_ctrl=000, sext imm6.
- 0110 ST: mem_wr=1, use_imm=1, alu_ctrl=000, sext imm6. Rt carries the store data.
- 1000–1011 R-type: wr_en=1, alu_ctrl = {1'b1, inst[13:12]}, Rd = inst[5:3].
- Any other opcode: decodes as a NOP and sets illegal.
- Sign extension replicates the field MSB up to DATA_W. DATA_W is never smaller than 12.
- The output register advances when out_valid=0 or ex_ready=1.
- Accept condition: in_valid & in_ready.
- in_ready = advance & ~hazard & ~halted & ~flush.
- Hazard (only when LOADUSE_STALL=1) is true when all of the following hold:
  - out_valid=1 and out_mem_rd=1;
  - out_rd equals the incoming Rs, or equals Rt when the incoming opcode reads Rt (BRANCH, ST, R-type).
- When the register advances without an accept (bubble, flush or halted), out_valid←0 and all control outputs ←0. PC and register fields are don't-care.

## Timing
- Reset: every registered output, halted and illegal are 0. in_ready follows its equation once rst_n is high.
- Latency is 1 cycle: an instruction accepted at edge N is presented on out_* from edge N until EX takes it.
- Backpressure: while ex_ready=0 and out_valid=1, all out_* hold stable and in_ready=0.
- Load-use: exactly one bubble is inserted. The dependent instruction is accepted on the cycle after the LD leaves.
- Flush has priority over every other event:
  - the current input is not accepted;
  - out_valid←0 on the next edge, even if ex_ready=0;
  - a HALT or illegal opcode presented during the flush cycle does not set the sticky flags.
- Simultaneous hazard and ex_ready=0: hold the output; no bubble yet.
- An rst_n assertion mid-stall or mid-halt clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset then 0x4A85 (ADDI) with in_valid=1 -> next cycle: out_valid=1, out_rd=5, out_rs=2, out_imm=0x0005, wr_en=1, use_imm=1.
- LD 0x5240 (r1←[r1]) followed by R-type 0x8248 (Rs=r1) -> the LD issues, then one cycle with out_valid=0 and in_ready=0, then the R-type issues. With LOADUSE_STALL=0 there is no bubble.
- ADDI with imm6=0x3F, DATA_W=16 -> out_imm=0xFFFF. JUMP with imm12=0x800 -> out_imm=0xF800.
- ex_ready=0 for 3 cycles with a valid output -> out_* stable, in_ready=0. After release, the next instruction is accepted.
- HALT 0x1000 accepted -> halted=1 and in_ready=0 permanently. Asserting rst_n low clears halted and out_valid asynchronously.
- flush=1 in the same cycle as a HALT input with ex_ready=0 -> next edge: out_valid=0, halted=0. Opcode 0xF then sets illegal=1 and issues as a NOP.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : ID stage of the 16-bit core. Decodes one instruction per cycle
//            into an ID/EX register with handshake, load-use stall, flush,
//            sticky halt and illegal-opcode flags.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int PC_W          = 16,
    parameter int DATA_W        = 16,
    parameter bit LOADUSE_STALL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_pc_plus2,
    input  logic              flush,
    input  logic              ex_ready,
    output logic [2:0]        rf_rs_addr,
    output logic [2:0]        rf_rt_addr,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_plus2,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_rs,
    output logic [2:0]        out_rt,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_alu_ctrl,
    output logic              out_use_imm,
    output logic              out_wr_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_branch,
    output logic              out_jump,
    output logic              halted,
    output logic              illegal
);

    localparam logic [3:0] c_OP_NOP    = 4'h0;
    localparam logic [3:0] c_OP_HALT   = 4'h1;
    localparam logic [3:0] c_OP_BRANCH = 4'h2;
    localparam logic [3:0] c_OP_JUMP   = 4'h3;
    localparam logic [3:0] c_OP_ADDI   = 4'h4;
    localparam logic [3:0] c_OP_LD     = 4'h5;
    localparam logic [3:0] c_OP_ST     = 4'h6;

    logic [3:0]        w_opcode;
    logic [2:0]        w_rd;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [DATA_W-1:0] w_imm6;
    logic [DATA_W-1:0] w_imm12;
    logic              w_reads_rt;
    logic              w_advance;
    logic              w_hazard;
    logic              w_accept;

    logic [DATA_W-1:0] w_imm;
    logic [2:0]        w_alu_ctrl;
    logic              w_use_imm;
    logic              w_wr_en;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic              w_branch;
    logic              w_jump;
    logic              w_is_halt;
    logic              w_is_illegal;

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_pc_plus2;
    logic [2:0]        r_rd;
    logic [2:0]        r_rs;
    logic [2:0]        r_rt;
    logic [DATA_W-1:0] r_imm;
    logic [2:0]        r_alu_ctrl;
    logic              r_use_imm;
    logic              r_wr_en;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_branch;
    logic              r_jump;
    logic              r_halted;
    logic              r_illegal;

    assign w_opcode   = in_inst[15:12];
    assign w_rs       = in_inst[8:6];
    assign w_rt       = in_inst[11:9];
    assign w_rd       = in_inst[14] ? in_inst[11:9] : in_inst[5:3];
    assign w_imm6     = {{(DATA_W-6){in_inst[5]}}, in_inst[5:0]};
    assign w_imm12    = {{(DATA_W-12){in_inst[11]}}, in_inst[11:0]};
    assign w_reads_rt = (w_opcode == c_OP_BRANCH) || (w_opcode == c_OP_ST) ||
                        (w_opcode[3:2] == 2'b10);

    assign rf_rs_addr = w_rs;
    assign rf_rt_addr = w_rt;

    generate
        if (LOADUSE_STALL) begin : g_loaduse
            assign w_hazard = r_valid && r_mem_rd &&
                              ((r_rd == w_rs) || (w_reads_rt && (r_rd == w_rt)));
        end else begin : g_no_loaduse
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign w_advance = !r_valid || ex_ready;
    assign in_ready  = w_advance && !w_hazard && !r_halted && !flush;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_imm        = '0;
        w_alu_ctrl   = 3'b000;
        w_use_imm    = 1'b0;
        w_wr_en      = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_is_halt    = 1'b0;
        w_is_illegal = 1'b0;
        case (w_opcode)
            c_OP_NOP:    ;
            c_OP_HALT:   w_is_halt = 1'b1;
            c_OP_BRANCH: begin w_branch = 1'b1; w_imm = w_imm6; end
            c_OP_JUMP:   begin w_jump = 1'b1; w_imm = w_imm12; end
            c_OP_ADDI:   begin w_wr_en = 1'b1; w_use_imm = 1'b1; w_imm = w_imm6; end
            c_OP_LD: begin
                w_wr_en   = 1'b1;
                w_mem_rd  = 1'b1;
                w_use_imm = 1'b1;
                w_imm     = w_imm6;
            end
            c_OP_ST:     begin w_mem_wr = 1'b1; w_use_imm = 1'b1; w_imm = w_imm6; end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                w_wr_en    = 1'b1;
                w_alu_ctrl = {1'b1, w_opcode[1:0]};
            end
            default:     w_is_illegal = 1'b1;
        endcase
    end

    // Flush kills the ID/EX entry even when EX is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus2 <= '0;
            r_rd       <= 3'b000;
            r_rs       <= 3'b000;
            r_rt       <= 3'b000;
            r_imm      <= '0;
            r_alu_ctrl <= 3'b000;
            r_use_imm  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_branch   <= 1'b0;
            r_jump     <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (flush || (w_advance && !w_accept)) begin
                r_valid    <= 1'b0;
                r_alu_ctrl <= 3'b000;
                r_use_imm  <= 1'b0;
                r_wr_en    <= 1'b0;
                r_mem_rd   <= 1'b0;
                r_mem_wr   <= 1'b0;
                r_branch   <= 1'b0;
                r_jump     <= 1'b0;
            end else if (w_accept) begin
                r_valid    <= 1'b1;
                r_pc       <= in_pc;
                r_pc_plus2 <= in_pc_plus2;
                r_rd       <= w_rd;
                r_rs       <= w_rs;
                r_rt       <= w_rt;
                r_imm      <= w_imm;
                r_alu_ctrl <= w_alu_ctrl;
                r_use_imm  <= w_use_imm;
                r_wr_en    <= w_wr_en;
                r_mem_rd   <= w_mem_rd;
                r_mem_wr   <= w_mem_wr;
                r_branch   <= w_branch;
                r_jump     <= w_jump;
            end
            if (w_accept && w_is_halt) begin
                r_halted <= 1'b1;
            end
            if (w_accept && w_is_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_pc_plus2 = r_pc_plus2;
    assign out_rd       = r_rd;
    assign out_rs       = r_rs;
    assign out_rt       = r_rt;
    assign out_imm      = r_imm;
    assign out_alu_ctrl = r_alu_ctrl;
    assign out_use_imm  = r_use_imm;
    assign out_wr_en    = r_wr_en;
    assign out_mem_rd   = r_mem_rd;
    assign out_mem_wr   = r_mem_wr;
    assign out_branch   = r_branch;
    assign out_jump     = r_jump;
    assign halted       = r_halted;
    assign illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed self-checking bench for decode_stage (stall and no-stall
//            builds driven from the same input stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_inst;
    logic [15:0] in_pc;
    logic [15:0] in_pc_plus2;
    logic        flush;
    logic        ex_ready;

    logic        in_ready;
    logic [2:0]  rf_rs_addr, rf_rt_addr;
    logic        out_valid;
    logic [15:0] out_pc, out_pc_plus2;
    logic [2:0]  out_rd, out_rs, out_rt;
    logic [15:0] out_imm;
    logic [2:0]  out_alu_ctrl;
    logic        out_use_imm, out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_jump;
    logic        halted, illegal;

    logic        ns_in_ready;
    logic [2:0]  ns_rf_rs_addr, ns_rf_rt_addr;
    logic        ns_out_valid;
    logic [15:0] ns_out_pc, ns_out_pc_plus2;
    logic [2:0]  ns_out_rd, ns_out_rs, ns_out_rt;
    logic [15:0] ns_out_imm;
    logic [2:0]  ns_out_alu_ctrl;
    logic        ns_out_use_imm, ns_out_wr_en, ns_out_mem_rd, ns_out_mem_wr;
    logic        ns_out_branch, ns_out_jump;
    logic        ns_halted, ns_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.PC_W(16), .DATA_W(16), .LOADUSE_STALL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_pc_plus2(in_pc_plus2),
        .flush(flush), .ex_ready(ex_ready),
        .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .out_valid(out_valid), .out_pc(out_pc), .out_pc_plus2(out_pc_plus2),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
        .out_alu_ctrl(out_alu_ctrl), .out_use_imm(out_use_imm), .out_wr_en(out_wr_en),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_branch(out_branch),
        .out_jump(out_jump), .halted(halted), .illegal(illegal)
    );

    decode_stage #(.PC_W(16), .DATA_W(16), .LOADUSE_STALL(1'b0)) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ns_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_pc_plus2(in_pc_plus2),
        .flush(flush), .ex_ready(ex_ready),
        .rf_rs_addr(ns_rf_rs_addr), .rf_rt_addr(ns_rf_rt_addr),
        .out_valid(ns_out_valid), .out_pc(ns_out_pc), .out_pc_plus2(ns_out_pc_plus2),
        .out_rd(ns_out_rd), .out_rs(ns_out_rs), .out_rt(ns_out_rt), .out_imm(ns_out_imm),
        .out_alu_ctrl(ns_out_alu_ctrl), .out_use_imm(ns_out_use_imm),
        .out_wr_en(ns_out_wr_en), .out_mem_rd(ns_out_mem_rd), .out_mem_wr(ns_out_mem_wr),
        .out_branch(ns_out_branch), .out_jump(ns_out_jump),
        .halted(ns_halted), .illegal(ns_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_inst = 16'h0000; in_pc = 16'h0000;
        in_pc_plus2 = 16'h0002; flush = 1'b0; ex_ready = 1'b1;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if ({out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_jump, out_use_imm} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 000000", {out_wr_en, out_mem_rd, out_mem_wr, out_branch, out_jump, out_use_imm}); end
        n_checks++; if ({halted, illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {halted, illegal}); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_inst = 16'h4A85; in_pc = 16'h0010; in_pc_plus2 = 16'h0012;
        #1;
        n_checks++; if ({rf_rs_addr, rf_rt_addr} !== {3'd2, 3'd5}) begin n_fail++; $display("FAIL addi_rf_addr got %h want %h", {rf_rs_addr, rf_rt_addr}, {3'd2, 3'd5}); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", out_valid); end
        n_checks++; if ({out_rd, out_rs, out_rt} !== {3'd5, 3'd2, 3'd5}) begin n_fail++; $display("FAIL addi_regs got %h want %h", {out_rd, out_rs, out_rt}, {3'd5, 3'd2, 3'd5}); end
        n_checks++; if (out_imm !== 16'h0005) begin n_fail++; $display("FAIL addi_imm got %h want 0005", out_imm); end
        n_checks++; if ({out_wr_en, out_use_imm, out_alu_ctrl, out_mem_rd, out_mem_wr} !== 7'b1100000) begin n_fail++; $display("FAIL addi_ctrl got %b want 1100000", {out_wr_en, out_use_imm, out_alu_ctrl, out_mem_rd, out_mem_wr}); end
        n_checks++; if ({out_pc, out_pc_plus2} !== {16'h0010, 16'h0012}) begin n_fail++; $display("FAIL addi_pc got %h want 00100012", {out_pc, out_pc_plus2}); end
    endtask

    task automatic test_sext();
        in_inst = 16'h403F;
        tick();
        n_checks++; if (out_imm !== 16'hFFFF) begin n_fail++; $display("FAIL sext_imm6 got %h want ffff", out_imm); end
        in_inst = 16'h3800;
        tick();
        n_checks++; if (out_imm !== 16'hF800) begin n_fail++; $display("FAIL sext_imm12 got %h want f800", out_imm); end
        n_checks++; if ({out_jump, out_wr_en, out_branch} !== 3'b100) begin n_fail++; $display("FAIL jump_ctrl got %b want 100", {out_jump, out_wr_en, out_branch}); end
        in_inst = 16'h2E7E;
        tick();
        n_checks++; if ({out_branch, out_imm} !== {1'b1, 16'hFFFE}) begin n_fail++; $display("FAIL branch got %h want 1fffe", {out_branch, out_imm}); end
    endtask

    task automatic test_loaduse();
        in_inst = 16'h5240;
        tick();
        n_checks++; if ({out_valid, out_mem_rd, out_wr_en, out_rd} !== {3'b111, 3'd1}) begin n_fail++; $display("FAIL ld_issue got %b want 111001", {out_valid, out_mem_rd, out_wr_en, out_rd}); end
        in_inst = 16'h8248;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall_ready got %b want 0", in_ready); end
        n_checks++; if (ns_in_ready !== 1'b1) begin n_fail++; $display("FAIL nostall_ready got %b want 1", ns_in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble got %b want 0", out_valid); end
        n_checks++; if ({ns_out_valid, ns_out_alu_ctrl} !== {1'b1, 3'b100}) begin n_fail++; $display("FAIL nostall_issue got %b want 1100", {ns_out_valid, ns_out_alu_ctrl}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL loaduse_resume_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if ({out_valid, out_wr_en, out_alu_ctrl, out_rd, out_rs} !== {2'b11, 3'b100, 3'd1, 3'd1}) begin n_fail++; $display("FAIL rtype_issue got %b want 11100001001", {out_valid, out_wr_en, out_alu_ctrl, out_rd, out_rs}); end
    endtask

    task automatic test_backpressure();
        in_inst = 16'h4A85;
        tick();
        ex_ready = 1'b0;
        in_inst = 16'h403F;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0", i, in_ready); end
            tick();
            n_checks++; if ({out_valid, out_imm, out_rd} !== {1'b1, 16'h0005, 3'd5}) begin n_fail++; $display("FAIL bp_hold cyc %0d got %h want 10005 rd5", i, {out_valid, out_imm, out_rd}); end
        end
        ex_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_imm !== 16'hFFFF) begin n_fail++; $display("FAIL bp_next got %h want ffff", out_imm); end
    endtask

    task automatic test_flush_halt();
        ex_ready = 1'b0; flush = 1'b1; in_inst = 16'h1000;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        n_checks++; if ({out_valid, halted} !== 2'b00) begin n_fail++; $display("FAIL flush_kill got %b want 00", {out_valid, halted}); end
        flush = 1'b0; ex_ready = 1'b1; in_inst = 16'hF000;
        tick();
        n_checks++; if ({illegal, out_valid, out_wr_en, out_jump} !== 4'b1100) begin n_fail++; $display("FAIL illegal_nop got %b want 1100", {illegal, out_valid, out_wr_en, out_jump}); end
    endtask

    task automatic test_halt();
        in_inst = 16'h1000;
        tick();
        n_checks++; if ({halted, out_valid, out_wr_en, out_mem_rd} !== 4'b1100) begin n_fail++; $display("FAIL halt_accept got %b want 1100", {halted, out_valid, out_wr_en, out_mem_rd}); end
        ex_ready = 1'b0; in_inst = 16'h4A85;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if ({in_ready, halted, out_valid} !== 3'b011) begin n_fail++; $display("FAIL halt_sticky cyc %0d got %b want 011", i, {in_ready, halted, out_valid}); end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({halted, illegal, out_valid} !== 3'b000) begin n_fail++; $display("FAIL async_reset got %b want 000", {halted, illegal, out_valid}); end
        in_valid = 1'b0; ex_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sext();
        test_loaduse();
        test_backpressure();
        test_flush_halt();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
